// File: rtl/scan_pkg.sv
// -----------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the scan sequencer and its decoder_2x4 consumer.
//   SEL_W     : width of the select bus (decoder_2x4 input A)
//   NUM_LINES : number of scanned lines / mask bits
//   state_t   : sequencer FSM encoding
// -----------------------------------------------------------------------------
package scan_pkg;

    localparam int SEL_W     = 2;
    localparam int NUM_LINES = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// scan_sequencer_if
// Control and status bundle between a scan controller (master) and the
// scan_sequencer (slave).
//   start, stop, pause : level controls
//   dir                : 0 = count up, 1 = count down
//   mask               : per-line enable
//   step_req/step_ack  : single-step handshake while paused
//   sel                : select to decoder_2x4 A
//   active, wrap       : status
// -----------------------------------------------------------------------------
interface scan_sequencer_if;

    logic                          start;
    logic                          stop;
    logic                          pause;
    logic                          dir;
    logic [scan_pkg::NUM_LINES-1:0] mask;
    logic                          step_req;
    logic                          step_ack;
    logic [scan_pkg::SEL_W-1:0]    sel;
    logic                          active;
    logic                          wrap;

    modport master (
        output start, stop, pause, dir, mask, step_req,
        input  step_ack, sel, active, wrap
    );

    modport slave (
        input  start, stop, pause, dir, mask, step_req,
        output step_ack, sel, active, wrap
    );

endinterface

// File: rtl/scan_next_index.sv
// -----------------------------------------------------------------------------
// scan_next_index
// Combinational search for the next enabled line after cur, walking cyclically
// in direction dir across the three other indices. Returns cur when no other
// line is enabled.
//   cur  : current index
//   dir  : 0 = up, 1 = down
//   mask : line enables
//   nxt  : next enabled index
//   wrap : the move crosses the 3/0 boundary (or stays in place)
// -----------------------------------------------------------------------------
module scan_next_index
    import scan_pkg::*;
(
    input  logic [SEL_W-1:0]     cur,
    input  logic                 dir,
    input  logic [NUM_LINES-1:0] mask,
    output logic [SEL_W-1:0]     nxt,
    output logic                 wrap
);

    logic [SEL_W-1:0] cand;
    logic             found;

    always_comb begin
        nxt   = cur;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i < NUM_LINES; i++) begin
            cand = dir ? (cur - SEL_W'(i)) : (cur + SEL_W'(i));
            if (!found && mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
        // A non-advancing move (only one line enabled) also counts as a wrap.
        wrap = dir ? (nxt >= cur) : (nxt <= cur);
    end

endmodule

// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
// Drives the 2-bit select of decoder_2x4, stepping through enabled lines at a
// programmable rate, with pause and handshaked single-step.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : scan_sequencer_if.slave (controls in, sel/status out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | stopped; sel holds, active = 0
// S_RUN   | auto-stepping every PRESCALE clocks
// S_PAUSE | prescaler frozen; one step per rising edge of step_req
// -----------------------------------------------------------------------------
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int PW       = 16
) (
    input  logic             clk,
    input  logic             reset,
    scan_sequencer_if.slave  bus
);

    localparam logic [PW-1:0] PRESC_TC = PW'(PRESCALE - 1);

    state_t           state, state_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic [SEL_W-1:0] sel_q, sel_nxt;
    logic             active_q, active_nxt;
    logic             wrap_q, wrap_nxt;
    logic             ack_q, ack_nxt;
    logic             step_req_d;
    logic             step_rise;
    logic             go_idle;

    logic [SEL_W-1:0] ni_cur;
    logic [SEL_W-1:0] ni_nxt;
    logic             ni_wrap;

    // In IDLE the search is seeded just before the first candidate so that
    // the same next-index logic yields the first enabled line from 0 (up)
    // or from 3 (down).
    assign ni_cur = (state == S_IDLE) ? (bus.dir ? SEL_W'(0) : SEL_W'(NUM_LINES - 1))
                                      : sel_q;

    scan_next_index u_next (
        .cur  (ni_cur),
        .dir  (bus.dir),
        .mask (bus.mask),
        .nxt  (ni_nxt),
        .wrap (ni_wrap)
    );

    assign step_rise = bus.step_req & ~step_req_d;
    assign go_idle   = bus.stop | (bus.mask == '0);

    always_comb begin
        state_nxt  = state;
        presc_nxt  = presc;
        sel_nxt    = sel_q;
        active_nxt = active_q;
        wrap_nxt   = 1'b0;
        ack_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                active_nxt = 1'b0;
                if (bus.start && !go_idle) begin
                    state_nxt  = S_RUN;
                    sel_nxt    = ni_nxt;
                    presc_nxt  = '0;
                    active_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (go_idle) begin
                    state_nxt  = S_IDLE;
                    active_nxt = 1'b0;
                    presc_nxt  = '0;
                end else if (bus.pause) begin
                    state_nxt = S_PAUSE;
                end else if (presc == PRESC_TC) begin
                    presc_nxt = '0;
                    sel_nxt   = ni_nxt;
                    wrap_nxt  = ni_wrap;
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
            S_PAUSE: begin
                if (go_idle) begin
                    state_nxt  = S_IDLE;
                    active_nxt = 1'b0;
                    presc_nxt  = '0;
                end else if (!bus.pause && bus.start) begin
                    state_nxt = S_RUN;
                end else if (step_rise) begin
                    sel_nxt  = ni_nxt;
                    wrap_nxt = ni_wrap;
                    ack_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                active_nxt = 1'b0;
                presc_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            presc      <= '0;
            sel_q      <= '0;
            active_q   <= 1'b0;
            wrap_q     <= 1'b0;
            ack_q      <= 1'b0;
            step_req_d <= 1'b0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            sel_q      <= sel_nxt;
            active_q   <= active_nxt;
            wrap_q     <= wrap_nxt;
            ack_q      <= ack_nxt;
            step_req_d <= bus.step_req;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.active   = active_q;
    assign bus.wrap     = wrap_q;
    assign bus.step_ack = ack_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer
// Directed bench for scan_sequencer (PRESCALE = 4). Expected outputs are
// queued as each step is driven and compared after the following edge.
// A local decoder_2x4 model turns sel into the one-hot line D.
// -----------------------------------------------------------------------------
module tb_scan_sequencer;
    import scan_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    scan_sequencer_if bus ();

    scan_sequencer #(
        .PRESCALE (4),
        .PW       (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      tag;
        logic [1:0] sel;
        logic       active;
        logic       wrap;
        logic       ack;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   ack_cnt = 0;

    logic [3:0] d_line;
    logic [3:0] oh_tbl [4];

    always_comb d_line = 4'b0001 << bus.sel;

    always @(negedge clk) if (bus.step_ack === 1'b1) ack_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            cmp("sb_underflow", 4'd1, 4'd0);
            return;
        end
        e = sb.pop_front();
        cmp({e.tag, ".sel"},    {2'b00, bus.sel},     {2'b00, e.sel});
        cmp({e.tag, ".active"}, {3'b000, bus.active}, {3'b000, e.active});
        cmp({e.tag, ".wrap"},   {3'b000, bus.wrap},   {3'b000, e.wrap});
        cmp({e.tag, ".ack"},    {3'b000, bus.step_ack}, {3'b000, e.ack});
    endtask

    task automatic expect_step(input string tag, input logic [1:0] s,
                               input logic a, input logic w, input logic k);
        exp_t e;
        e.tag = tag; e.sel = s; e.active = a; e.wrap = w; e.ack = k;
        sb.push_back(e);
        tick();
        check_out();
    endtask

    initial begin
        logic [1:0] t2_seq [3];
        logic       t2_wrp [3];
        logic [1:0] prev;
        int         ack_base;

        oh_tbl[0] = 4'b0001; oh_tbl[1] = 4'b0010;
        oh_tbl[2] = 4'b0100; oh_tbl[3] = 4'b1000;
        t2_seq[0] = 2'd1; t2_seq[1] = 2'd3; t2_seq[2] = 2'd1;
        t2_wrp[0] = 1'b0; t2_wrp[1] = 1'b1; t2_wrp[2] = 1'b0;

        reset = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.dir = 1'b0;
        bus.mask = 4'h0;  bus.step_req = 1'b0;
        tick();
        expect_step("reset", 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // up scan, all lines enabled, with decoder one-hot
        bus.mask = 4'hF; bus.dir = 1'b0; bus.start = 1'b1;
        expect_step("t1_entry", 2'd0, 1'b1, 1'b0, 1'b0);
        cmp("t1_dec0", d_line, oh_tbl[0]);
        bus.start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            prev = 2'(k - 1);
            for (int j = 0; j < 3; j++) expect_step("t1_hold", prev, 1'b1, 1'b0, 1'b0);
            expect_step("t1_step", 2'(k % 4), 1'b1, 1'(k == 4), 1'b0);
            cmp("t1_dec", d_line, oh_tbl[k % 4]);
        end
        expect_step("t1_wrap_clear", 2'd0, 1'b1, 1'b0, 1'b0);
        bus.stop = 1'b1;
        expect_step("t1_stop", 2'd0, 1'b0, 1'b0, 1'b0);
        bus.stop = 1'b0;

        // down scan over lines 1 and 3
        bus.mask = 4'b1010; bus.dir = 1'b1; bus.start = 1'b1;
        expect_step("t2_entry", 2'd3, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        prev = 2'd3;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) expect_step("t2_hold", prev, 1'b1, 1'b0, 1'b0);
            expect_step("t2_step", t2_seq[k], 1'b1, t2_wrp[k], 1'b0);
            prev = t2_seq[k];
        end
        bus.stop = 1'b1;
        expect_step("t2_stop", 2'd1, 1'b0, 1'b0, 1'b0);
        bus.stop = 1'b0;

        // pause, single-step handshake, resume from held prescaler
        bus.mask = 4'hF; bus.dir = 1'b0; bus.start = 1'b1;
        expect_step("t3_entry", 2'd0, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        expect_step("t3_run1", 2'd0, 1'b1, 1'b0, 1'b0);
        expect_step("t3_run2", 2'd0, 1'b1, 1'b0, 1'b0);
        bus.pause = 1'b1;
        expect_step("t3_pause", 2'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) expect_step("t3_frozen", 2'd0, 1'b1, 1'b0, 1'b0);
        ack_base = ack_cnt;
        for (int i = 1; i <= 3; i++) begin
            bus.step_req = 1'b1;
            expect_step("t3_step", 2'(i), 1'b1, 1'b0, 1'b1);
            bus.step_req = 1'b0;
            expect_step("t3_gap", 2'(i), 1'b1, 1'b0, 1'b0);
        end
        bus.step_req = 1'b1;
        expect_step("t3_held_first", 2'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) expect_step("t3_held", 2'd0, 1'b1, 1'b0, 1'b0);
        bus.step_req = 1'b0;
        expect_step("t3_held_release", 2'd0, 1'b1, 1'b0, 1'b0);
        cmp("t3_ack_count", 4'(ack_cnt - ack_base), 4'd4);
        bus.pause = 1'b0; bus.start = 1'b1;
        expect_step("t3_resume", 2'd0, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        expect_step("t3_presc3", 2'd0, 1'b1, 1'b0, 1'b0);
        expect_step("t3_resume_step", 2'd1, 1'b1, 1'b0, 1'b0);
        bus.step_req = 1'b1;
        expect_step("t3_req_in_run", 2'd1, 1'b1, 1'b0, 1'b0);
        bus.step_req = 1'b0;

        // stop in RUN at sel=2, then start+stop in IDLE
        expect_step("t4_hold", 2'd1, 1'b1, 1'b0, 1'b0);
        expect_step("t4_hold", 2'd1, 1'b1, 1'b0, 1'b0);
        expect_step("t4_step", 2'd2, 1'b1, 1'b0, 1'b0);
        bus.stop = 1'b1;
        expect_step("t4_stop_run", 2'd2, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        expect_step("t4_start_stop", 2'd2, 1'b0, 1'b0, 1'b0);
        expect_step("t4_start_stop2", 2'd2, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0; bus.stop = 1'b0;

        // reset mid-RUN at sel=3, prescaler=2
        bus.start = 1'b1;
        expect_step("t5_entry", 2'd0, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            prev = 2'(k - 1);
            for (int j = 0; j < 3; j++) expect_step("t5_hold", prev, 1'b1, 1'b0, 1'b0);
            expect_step("t5_step", 2'(k), 1'b1, 1'b0, 1'b0);
        end
        expect_step("t5_p1", 2'd3, 1'b1, 1'b0, 1'b0);
        expect_step("t5_p2", 2'd3, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        expect_step("t5_reset", 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // mask=0 in RUN, and start with mask=0
        bus.start = 1'b1;
        expect_step("t6_entry", 2'd0, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.mask = 4'h0;
        expect_step("t6_mask0", 2'd0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        expect_step("t6_start_mask0", 2'd0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream driver for decoder_2x4: produces the 2-bit select `A` that the decoder turns into a one-hot line (digit/row scanning).
- Steps through indices 0..3 at a programmable rate, skipping masked indices, in either direction.
- Supports a paused single-step mode with a req/ack handshake.
- Purely synchronous; `sel` connects directly to decoder_2x4 `A`.

Parameters:
- PRESCALE, 4, clk cycles per automatic step in RUN; legal range 1..65535.
- PW, 16, prescaler counter width; must hold PRESCALE-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level; enter or resume RUN.
- stop  input  1  level; return to IDLE.
- pause  input  1  level; RUN to PAUSE while high.
- dir  input  1  0 = up (0→1→2→3→0), 1 = down (3→2→1→0→3); sampled at each step.
- mask  input  4  bit i = 1 means index i is enabled.
- step_req  input  1  single-step request; honoured only in PAUSE.
- step_ack  output  1  one-cycle pulse when a requested step has been applied.
- sel  output  2  select to decoder_2x4 `A`.
- active  output  1  1 in RUN or PAUSE.
- wrap  output  1  one-cycle pulse when a step crosses the 3/0 boundary.

Behaviour:
- Reset is synchronous, active-high; all outputs are registered. The reset value of every output and state element is:
  - state = IDLE, sel = 0, active = 0, wrap = 0, step_ack = 0, prescaler = 0.
- Reset asserted mid-operation aborts immediately on that edge; a pending step_req is dropped.
- States: IDLE, RUN, PAUSE.
- IDLE:
  - sel holds its value.
  - start=1 and stop=0 and mask≠0 → RUN on the next edge.
  - On entry to RUN: sel = first enabled index scanning from 0 (dir=0) or from 3 (dir=1), prescaler = 0, active = 1.
  - start with mask=0 is ignored.
- RUN:
  - prescaler counts 0..PRESCALE-1.
  - At PRESCALE-1: prescaler → 0 and sel → next(sel, dir, mask).
  - next() searches the 3 indices following sel, cyclically in direction dir, and returns the first enabled one. If none is enabled, it returns sel.
  - PRESCALE=1 gives one step every cycle.
- wrap:
  - Pulses on the cycle after a step where new ≤ old (dir=0) or new ≥ old (dir=1).
  - If sel is the only enabled index, wrap pulses on every step.
- pause=1 in RUN → PAUSE. The prescaler freezes and keeps its value.
- pause=0 with start=1 in PAUSE → RUN; the prescaler resumes from its held value.
- PAUSE single-step:
  - step_req=1 applies one step (sel → next(), wrap rule as above) on the next edge.
  - step_ack=1 on that same edge, for exactly one cycle.
  - step_req must drop before another step. Step_req is edge-detected internally, so holding it high yields a single step.
  - step_req in IDLE or RUN is ignored and never produces step_ack.
- Priority on simultaneous events: reset > stop > mask=0 > pause > start > step/prescaler.
- stop in RUN or PAUSE → IDLE next edge. active = 0 and the prescaler clears; sel keeps its last value.
- Mask changes in RUN take effect at the next step.
- mask becoming 0 in RUN or PAUSE → IDLE next edge, as for stop.
- Masking the current sel does not move it until the next step.

Decomposition:
- Shared package `scan_pkg`:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_PAUSE=2'd2;
  - SEL_W=2 and NUM_LINES=4, shared with the decoder_2x4 width.
- One sub-module, `scan_next_index`: combinational next(sel, dir, mask), plus a wrap-flag output.
- FSM, prescaler and edge detector stay in the top module.

Test Plan:
- Reset, then start with mask=4'b1111, dir=0, PRESCALE=4 → active=1 one cycle later, sel=0. Then sel sequence 1,2,3,0 every 4 clocks; wrap pulses once, on the 3→0 step.
- mask=4'b1010, dir=1, start → sel=3, then 1, 3, 1…; wrap pulses on each 1→3 step.
- RUN, pause=1 for 20 cycles → sel frozen. Three step_req pulses → sel advances 3 times and step_ack pulses exactly 3 times. step_req held high 5 cycles → only one step.
- start and stop both high in IDLE → state stays IDLE, active=0. stop in RUN at sel=2 → active=0 next edge, sel stays 2.
- Reset asserted mid-RUN at sel=3 with the prescaler at 2 → next edge sel=0, active=0, wrap=0. mask=0 in RUN → IDLE next edge.
- Integration with decoder_2x4 → decoder output D follows the one-hot sequence 0001, 0010, 0100, 1000 for dir=0, mask=1111.
